ucsbece154b_perf_monitor: RTL and testbench

- Synthesizable performance-monitor block for the N-wide superscalar RISC-V core; sits beside the datapath and probes decode/fetch/execute signals.
- Counts cycles, issued instructions, branches/jumps and their mispredictions.
- Detects program end (every fetch slot parked on a NOP at an unchanged PC) and enforces a cycle timeout.
- Counters are readable through a registered select port, so results are available in silicon without a testbench.

---
 rtl/ucsbece154b_perf_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_ucsbece154b_perf_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_perf_monitor.sv
// ucsbece154b_perf_monitor: cycle/instruction/branch/jump counters for the N-wide core,
// with program-end (NOP park) detection, cycle timeout and a registered readout port.
// Optional per-slot issue counters are built when PERF_PER_SLOT_EN is defined.
module ucsbece154b_perf_monitor #(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 500,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic [NUM_SLOTS*32-1:0] instrD_i,
    input  logic [NUM_SLOTS*32-1:0] pcF_i,
    input  logic [NUM_SLOTS*32-1:0] instrF_i,
    input  logic [6:0]              opE_i,
    input  logic                    mispredict_i,
    input  logic                    branch_taken_f_i,
    input  logic [3:0]              sel_i,
    output logic [CNT_W-1:0]        rdata_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic                    overflow_o
);

    localparam int unsigned SumW = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StHalted  = 2'd2,
        StTimeout = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cycle_q, instr_q, branch_q, branch_miss_q, jump_q, jump_miss_q;
    logic [NUM_SLOTS*32-1:0] prevpc_q;
    logic                    pc_valid_q;
    logic                    done_q, timeout_q, overflow_q;
    logic [CNT_W-1:0]        rdata_q;
    logic [CNT_W-1:0]        rdata_d;

    // Bit CNT_W of the result is the carry-out; on carry the value clamps to all-ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {1'b0, inc};
        if (s[CNT_W]) s = {1'b1, {CNT_W{1'b1}}};
        return s;
    endfunction

    logic [NUM_SLOTS-1:0] slot_issue;
    logic [SumW-1:0]      issue_cnt;
    logic                 halt_cond;
    logic                 is_branch, is_jump;

    // Per-slot issue qualification, issue sum and program-end detection
    always_comb begin
        issue_cnt = '0;
        halt_cond = pc_valid_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_issue[k] = (instrD_i[32*k +: 32] != 32'h0) &&
                            (instrD_i[32*k +: 32] != NOP_INSN);
            issue_cnt = issue_cnt + SumW'(slot_issue[k]);
            if ((pcF_i[32*k +: 32] != prevpc_q[32*k +: 32]) ||
                (instrF_i[32*k +: 32] != NOP_INSN)) begin
                halt_cond = 1'b0;
            end
        end
    end

    assign is_branch = (opE_i == 7'b1100011);
    assign is_jump   = (opE_i == 7'b1101111) || (opE_i == 7'b1100111);

    logic [CNT_W:0] cyc_add, ins_add, br_add, brm_add, jmp_add, jmpm_add;

    assign cyc_add  = sat_add(cycle_q, CNT_W'(1'b1));
    assign ins_add  = sat_add(instr_q, CNT_W'(issue_cnt));
    assign br_add   = sat_add(branch_q, CNT_W'(is_branch));
    assign brm_add  = sat_add(branch_miss_q, CNT_W'(is_branch & mispredict_i));
    assign jmp_add  = sat_add(jump_q, CNT_W'(is_jump));
    assign jmpm_add = sat_add(jump_miss_q, CNT_W'(is_jump & ~branch_taken_f_i));

    // Compare in a widened domain so a MAX_CYCLES wider than CNT_W never aliases.
    logic [CNT_W+31:0] cyc_ext;
    logic              timeout_hit;
    assign cyc_ext     = {32'b0, cyc_add[CNT_W-1:0]};
    assign timeout_hit = (cyc_ext == (CNT_W+32)'(MAX_CYCLES));

    logic slot_ovf;

`ifdef PERF_PER_SLOT_EN
    logic [CNT_W-1:0] slot_cnt_q [NUM_SLOTS];
    logic [CNT_W:0]   slot_add   [NUM_SLOTS];

    // Per-slot saturating increments
    always_comb begin
        slot_ovf = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_add[k] = sat_add(slot_cnt_q[k], CNT_W'(slot_issue[k]));
            slot_ovf    = slot_ovf | slot_add[k][CNT_W];
        end
    end

    // Per-slot counters follow the same run/halt/clear rules as the shared counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) slot_cnt_q[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NUM_SLOTS; k++) slot_cnt_q[k] <= '0;
        end else if (state_q == StRun && en_i && !halt_cond) begin
            for (int k = 0; k < NUM_SLOTS; k++) slot_cnt_q[k] <= slot_add[k][CNT_W-1:0];
        end
    end
`else
    assign slot_ovf = 1'b0;
`endif

    logic any_ovf;
    assign any_ovf = cyc_add[CNT_W] | ins_add[CNT_W] | br_add[CNT_W] | brm_add[CNT_W] |
                     jmp_add[CNT_W] | jmpm_add[CNT_W] | slot_ovf;

    logic [31:0] status_w;
    assign status_w = {27'b0, overflow_q, timeout_q, done_q, state_q};

    // Readout select; slot indices beyond NUM_SLOTS (or no per-slot build) read zero
    always_comb begin
        rdata_d = '0;
        case (sel_i)
            4'd0: rdata_d = cycle_q;
            4'd1: rdata_d = instr_q;
            4'd2: rdata_d = branch_q;
            4'd3: rdata_d = branch_miss_q;
            4'd4: rdata_d = jump_q;
            4'd5: rdata_d = jump_miss_q;
            4'd6: rdata_d = CNT_W'(status_w);
            4'd7: rdata_d = CNT_W'(MAX_CYCLES);
            default: begin
`ifdef PERF_PER_SLOT_EN
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (sel_i[3] && (sel_i[2:0] == 3'(k))) rdata_d = slot_cnt_q[k];
                end
`endif
            end
        endcase
    end

    // Control FSM with counters, flags and registered readout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cycle_q       <= '0;
            instr_q       <= '0;
            branch_q      <= '0;
            branch_miss_q <= '0;
            jump_q        <= '0;
            jump_miss_q   <= '0;
            prevpc_q      <= '0;
            pc_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (clear_i) begin
                state_q       <= StIdle;
                cycle_q       <= '0;
                instr_q       <= '0;
                branch_q      <= '0;
                branch_miss_q <= '0;
                jump_q        <= '0;
                jump_miss_q   <= '0;
                prevpc_q      <= '0;
                pc_valid_q    <= 1'b0;
                done_q        <= 1'b0;
                timeout_q     <= 1'b0;
                overflow_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (en_i) state_q <= StRun;
                    end
                    StRun: begin
                        if (en_i) begin
                            if (halt_cond) begin
                                // Halt wins over a coincident timeout; nothing counts
                                state_q <= StHalted;
                                done_q  <= 1'b1;
                            end else begin
                                cycle_q       <= cyc_add[CNT_W-1:0];
                                instr_q       <= ins_add[CNT_W-1:0];
                                branch_q      <= br_add[CNT_W-1:0];
                                branch_miss_q <= brm_add[CNT_W-1:0];
                                jump_q        <= jmp_add[CNT_W-1:0];
                                jump_miss_q   <= jmpm_add[CNT_W-1:0];
                                overflow_q    <= overflow_q | any_ovf;
                                prevpc_q      <= pcF_i;
                                pc_valid_q    <= 1'b1;
                                if (timeout_hit) begin
                                    state_q   <= StTimeout;
                                    timeout_q <= 1'b1;
                                end
                            end
                        end
                    end
                    StHalted: begin
                    end
                    StTimeout: begin
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench for ucsbece154b_perf_monitor: default instance plus a short-timeout
// instance and a narrow-counter instance sharing the probe inputs.
module tb_ucsbece154b_perf_monitor;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [6:0]  OP_BR  = 7'b1100011;
    localparam logic [6:0]  OP_JAL = 7'b1101111;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        en0, en1, en2;
    logic [63:0] instrD, pcF, instrF;
    logic [6:0]  opE;
    logic        mp, bt;
    logic [3:0]  sel;

    logic [31:0] rdata0, rdata1;
    logic [3:0]  rdata2;
    logic        done0, to0, ovf0;
    logic        done1, to1, ovf1;
    logic        done2, to2, ovf2;

    int compared;
    int mismatched;
    logic [31:0] pc_base;

    ucsbece154b_perf_monitor dut (
        .clk(clk), .reset(reset), .clear_i(clear), .en_i(en0),
        .instrD_i(instrD), .pcF_i(pcF), .instrF_i(instrF), .opE_i(opE),
        .mispredict_i(mp), .branch_taken_f_i(bt), .sel_i(sel),
        .rdata_o(rdata0), .done_o(done0), .timeout_o(to0), .overflow_o(ovf0)
    );

    ucsbece154b_perf_monitor #(.MAX_CYCLES(8)) dut_to (
        .clk(clk), .reset(reset), .clear_i(clear), .en_i(en1),
        .instrD_i(instrD), .pcF_i(pcF), .instrF_i(instrF), .opE_i(opE),
        .mispredict_i(mp), .branch_taken_f_i(bt), .sel_i(sel),
        .rdata_o(rdata1), .done_o(done1), .timeout_o(to1), .overflow_o(ovf1)
    );

    ucsbece154b_perf_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .clear_i(clear), .en_i(en2),
        .instrD_i(instrD), .pcF_i(pcF), .instrF_i(instrF), .opE_i(opE),
        .mispredict_i(mp), .branch_taken_f_i(bt), .sel_i(sel),
        .rdata_o(rdata2), .done_o(done2), .timeout_o(to2), .overflow_o(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance fetch PCs so the halt condition never matches
    task automatic tick();
        pc_base = pc_base + 32'd8;
        pcF = {pc_base + 32'd4, pc_base};
        step();
    endtask

    task automatic rd0(input logic [3:0] s, input string tag, input logic [31:0] exp);
        sel = s;
        step();
        check(tag, rdata0, exp);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset  = 1'b0;
        clear  = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        instrD = {ADDI, ADDI};
        instrF = {ADDI, ADDI};
        opE = 7'd0; mp = 1'b0; bt = 1'b1; sel = 4'd0;
        pc_base = 32'h100;
        pcF = {pc_base + 32'd4, pc_base};

        #12;
        check("rst_rdata", rdata0, 0);
        check("rst_done", done0, 0);
        check("rst_timeout", to0, 0);
        check("rst_overflow", ovf0, 0);
        reset = 1'b1;

        // Enable edge, then 10 counted cycles
        en0 = 1'b1;
        tick();
        repeat (10) tick();
        en0 = 1'b0;
        rd0(4'd0, "cycle10", 10);
        rd0(4'd1, "instr20", 20);
        rd0(4'd2, "branch0", 0);
        rd0(4'd3, "bmiss0", 0);
        rd0(4'd4, "jump0", 0);
        rd0(4'd5, "jmiss0", 0);
        rd0(4'd6, "status_run", 1);
        rd0(4'd7, "max_cycles", 500);
        rd0(4'd8, "slot_none", 0);

        // Branches and jumps
        en0 = 1'b1;
        opE = OP_BR;
        mp = 1'b0; tick();
        mp = 1'b1; tick();
        mp = 1'b0; tick();
        tick();
        opE = OP_JAL;
        bt = 1'b0; tick();
        bt = 1'b1; tick();
        opE = 7'd0;
        en0 = 1'b0;
        rd0(4'd2, "branch4", 4);
        rd0(4'd3, "bmiss1", 1);
        rd0(4'd4, "jump2", 2);
        rd0(4'd5, "jmiss1", 1);
        rd0(4'd0, "cycle16", 16);
        rd0(4'd1, "instr32", 32);

        // Park both slots on NOP at fixed PCs; first edge counts, second halts
        en0 = 1'b1;
        instrD = {NOP, NOP};
        instrF = {NOP, NOP};
        pcF = {32'h44, 32'h40};
        step();
        check("done_first_edge", done0, 0);
        step();
        check("done_second_edge", done0, 1);
        rd0(4'd6, "status_halt", 6);
        rd0(4'd0, "cycle_halt", 17);
        repeat (3) step();
        rd0(4'd0, "cycle_frozen", 17);
        rd0(4'd1, "instr_frozen", 32);

        // Clear back to idle
        en0 = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd0(4'd6, "status_clr", 0);
        check("done_clr", done0, 0);

        // Run 5 cycles, then asynchronous reset mid-cycle
        instrD = {ADDI, ADDI};
        instrF = {ADDI, ADDI};
        sel = 4'd0;
        en0 = 1'b1;
        tick();
        repeat (5) tick();
        check("rdata_latency", rdata0, 4);
        #3 reset = 1'b0;
        #1;
        check("async_rst_rdata", rdata0, 0);
        check("async_rst_done", done0, 0);
        #1 reset = 1'b1;
        tick();
        repeat (3) tick();
        en0 = 1'b0;
        rd0(4'd0, "cycle_restart", 3);

        // Timeout instance (MAX_CYCLES=8)
        en1 = 1'b1;
        tick();
        repeat (7) tick();
        check("timeout_before", to1, 0);
        tick();
        check("timeout_hit", to1, 1);
        repeat (3) tick();
        sel = 4'd0;
        step();
        check("timeout_cycle8", rdata1, 8);
        sel = 4'd6;
        step();
        check("timeout_status", rdata1, 11);
        check("timeout_held", to1, 1);
        en1 = 1'b0;

        // Saturation instance (CNT_W=4)
        en2 = 1'b1;
        tick();
        repeat (20) tick();
        en2 = 1'b0;
        sel = 4'd0;
        step();
        check("sat_cycle", rdata2, 15);
        check("sat_overflow", ovf2, 1);
        sel = 4'd1;
        step();
        check("sat_instr", rdata2, 15);
        clear = 1'b1;
        step();
        clear = 1'b0;
        sel = 4'd0;
        step();
        check("clr_cycle", rdata2, 0);
        check("clr_overflow", ovf2, 0);
        sel = 4'd1;
        step();
        check("clr_instr", rdata2, 0);
        sel = 4'd6;
        step();
        check("clr_status", rdata2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
